// File: rtl/rat_int_sequencer_if.sv
// Bus between the RAT instruction-cycle sequencer and its surroundings:
// opcode/IRQ/mask inputs and the phase, interrupt and flag-shadow outputs.
interface rat_int_sequencer_if #(
  parameter int N_IRQ = 4,
  parameter int VEC_W = 10
);
  logic [4:0]       OPCODE_HI_5;
  logic [1:0]       OPCODE_LOW_2;
  logic [N_IRQ-1:0] IRQ;
  logic             MASK_WE;
  logic [N_IRQ-1:0] MASK_IN;

  logic             FETCH_EN;
  logic             EXEC_EN;
  logic             INTR_EN;
  logic             RST;
  logic             I_FLAG;
  logic [N_IRQ-1:0] INT_ACK;
  logic [VEC_W-1:0] INT_VECTOR;
  logic             FLG_SHAD_LD;
  logic             FLG_SHAD_RESTORE;
  logic [N_IRQ-1:0] PENDING;

  modport master (
    output OPCODE_HI_5, OPCODE_LOW_2, IRQ, MASK_WE, MASK_IN,
    input  FETCH_EN, EXEC_EN, INTR_EN, RST, I_FLAG, INT_ACK, INT_VECTOR,
           FLG_SHAD_LD, FLG_SHAD_RESTORE, PENDING
  );

  modport slave (
    input  OPCODE_HI_5, OPCODE_LOW_2, IRQ, MASK_WE, MASK_IN,
    output FETCH_EN, EXEC_EN, INTR_EN, RST, I_FLAG, INT_ACK, INT_VECTOR,
           FLG_SHAD_LD, FLG_SHAD_RESTORE, PENDING
  );
endinterface

// File: rtl/rat_int_sequencer.sv
// RAT instruction-cycle sequencer (INIT/FETCH/EXEC/INTR) with N_IRQ prioritised, maskable IRQs.
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchroniser per IRQ ahead of edge detection.

module rat_int_sequencer_chan (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pend
);
  logic w_lvl;
  logic w_rise;
  logic r_prev;
  logic r_pend;

`ifdef IRQ_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_irq};
  end
  assign w_lvl = r_sync[1];
`else
  assign w_lvl = i_irq;
`endif

  assign w_rise = w_lvl & ~r_prev;

  // A fresh edge on the ack cycle beats the clear, so the request is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= w_lvl;
      r_pend <= (r_pend & ~i_clr) | w_rise;
    end
  end

  assign o_pend = r_pend;
endmodule

module rat_int_sequencer #(
  parameter int               N_IRQ     = 4,
  parameter int               VEC_W     = 10,
  parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(10'h3FF),
  parameter logic [6:0]       OP_SEI    = 7'b0110100,
  parameter logic [6:0]       OP_CLI    = 7'b0110101,
  parameter logic [6:0]       OP_RETID  = 7'b0110110,
  parameter logic [6:0]       OP_RETIE  = 7'b0110111
) (
  input logic                CLK,
  input logic                RESET,
  rat_int_sequencer_if.slave bus
);
  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_INTR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_iflag;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] w_pend;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_sel_oh;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_vld;
  logic [N_IRQ-1:0] w_clr;
  logic [6:0]       w_opcode;
  logic             w_take;

  assign w_opcode = {bus.OPCODE_HI_5, bus.OPCODE_LOW_2};

  for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
    rat_int_sequencer_chan u_chan (
      .i_clk  (CLK),
      .i_rst  (RESET),
      .i_irq  (bus.IRQ[g]),
      .i_clr  (w_clr[g]),
      .o_pend (w_pend[g])
    );
  end

  assign w_elig = w_pend & r_mask;
  assign w_take = (|w_elig) & r_iflag;

  // Scan high-to-low so the lowest eligible index is the one that sticks.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    w_sel_vld = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_vld   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_INIT;
    case (r_state)
      S_INIT:  w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = w_take ? S_INTR : S_FETCH;
      S_INTR:  w_next = S_FETCH;
      default: w_next = S_INIT;
    endcase
  end

  always_comb begin
    bus.FETCH_EN         = 1'b0;
    bus.EXEC_EN          = 1'b0;
    bus.INTR_EN          = 1'b0;
    bus.RST              = 1'b0;
    bus.INT_ACK          = '0;
    bus.INT_VECTOR       = '0;
    bus.FLG_SHAD_LD      = 1'b0;
    bus.FLG_SHAD_RESTORE = 1'b0;
    w_clr                = '0;
    case (r_state)
      S_INIT:  bus.RST = 1'b1;
      S_FETCH: bus.FETCH_EN = 1'b1;
      S_EXEC: begin
        bus.EXEC_EN          = 1'b1;
        bus.FLG_SHAD_RESTORE = (w_opcode == OP_RETID) || (w_opcode == OP_RETIE);
      end
      S_INTR: begin
        bus.INTR_EN     = 1'b1;
        bus.FLG_SHAD_LD = 1'b1;
        bus.INT_ACK     = w_sel_oh;
        w_clr           = w_sel_oh;
        if (w_sel_vld) bus.INT_VECTOR = VEC_BASE - VEC_W'(w_sel_idx);
      end
      default: bus.RST = 1'b0;
    endcase
  end

  // Decision in EXEC sees the old flag; the opcode's effect lands on this edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_iflag <= 1'b0;
    end else begin
      case (r_state)
        S_EXEC: begin
          if (w_opcode == OP_SEI || w_opcode == OP_RETIE)      r_iflag <= 1'b1;
          else if (w_opcode == OP_CLI || w_opcode == OP_RETID) r_iflag <= 1'b0;
        end
        S_INTR:  r_iflag <= 1'b0;
        default: r_iflag <= r_iflag;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)            r_mask <= '1;
    else if (bus.MASK_WE) r_mask <= bus.MASK_IN;
  end

  assign bus.I_FLAG  = r_iflag;
  assign bus.PENDING = w_pend;
endmodule

// File: tb/tb_rat_int_sequencer.sv
// Scoreboard bench for rat_int_sequencer: directed interrupt scenarios plus random traffic
// against a cycle-level behavioural model of the sequencer rules.
module tb_rat_int_sequencer;
  localparam int N  = 4;
  localparam int VW = 10;
  localparam bit [6:0] OP_SEI   = 7'b0110100;
  localparam bit [6:0] OP_CLI   = 7'b0110101;
  localparam bit [6:0] OP_RETID = 7'b0110110;
  localparam bit [6:0] OP_RETIE = 7'b0110111;
  localparam bit [6:0] OP_NOP   = 7'b0000000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  rat_int_sequencer_if #(.N_IRQ(N), .VEC_W(VW)) bus ();
  rat_int_sequencer #(.N_IRQ(N), .VEC_W(VW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic fe, ee, ie, rst, ifl;
    logic [N-1:0] ack;
    logic [VW-1:0] vec;
    logic sld, srs;
    logic [N-1:0] pend;
  } exp_t;

  exp_t q[$];
  logic [N+VW-1:0] exp_log[$];
  logic [N+VW-1:0] obs_log[$];
  event chk_now;

  // model: phase 0=INIT 1=FETCH 2=EXEC 3=INTR
  int m_ph;
  bit m_if;
  bit [N-1:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  bit [6:0] d_op;
  bit [N-1:0] d_irq, d_min, irq_v;
  bit d_we, reedge, done, log_en;
  int checks = 0, errors = 0, timeouts = 0;

  function automatic int sel_ch(input bit [N-1:0] e);
    for (int i = 0; i < N; i++) if (e[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_if = 0; m_pend = '0; m_mask = '1; m_prev = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_adv();
    bit [N-1:0] lvl, rise, elig;
    int s, nph;
    elig = m_pend & m_mask;
    s = sel_ch(elig);
    case (m_ph)
      0: nph = 1;
      1: nph = 2;
      2: nph = (elig != 0 && m_if) ? 3 : 1;
      default: nph = 1;
    endcase
    if (m_ph == 2) begin
      if (d_op == OP_SEI || d_op == OP_RETIE) m_if = 1;
      else if (d_op == OP_CLI || d_op == OP_RETID) m_if = 0;
    end else if (m_ph == 3) m_if = 0;
`ifdef IRQ_SYNC_EN
    lvl = m_s2; m_s2 = m_s1; m_s1 = d_irq;
`else
    lvl = d_irq;
`endif
    rise = lvl & ~m_prev;
    m_prev = lvl;
    if (m_ph == 3 && s >= 0) m_pend[s] = 0;
    m_pend = m_pend | rise;
    if (d_we) m_mask = d_min;
    m_ph = nph;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int s;
    e = '0;
    e.pend = m_pend;
    e.ifl = m_if;
    case (m_ph)
      0: e.rst = 1;
      1: e.fe = 1;
      2: begin e.ee = 1; e.srs = (d_op == OP_RETID || d_op == OP_RETIE); end
      default: begin
        e.ie = 1; e.sld = 1;
        s = sel_ch(m_pend & m_mask);
        if (s >= 0) begin e.ack[s] = 1; e.vec = 10'h3FF - 10'(s); end
      end
    endcase
    return e;
  endfunction

  task automatic step(input bit [6:0] op, input bit we, input bit [N-1:0] mi, input bit rst);
    @(posedge CLK);
    if (RESET) model_reset(); else model_adv();
    #1;
    if (reedge && m_ph == 3) begin irq_v[1] = 1; reedge = 0; end
    d_op = op; d_irq = irq_v; d_we = we; d_min = mi;
    bus.OPCODE_HI_5 = op[6:2]; bus.OPCODE_LOW_2 = op[1:0];
    bus.IRQ = irq_v; bus.MASK_WE = we; bus.MASK_IN = mi;
    RESET = rst;
    if (rst) model_reset();
    q.push_back(expect_now());
  endtask

  task automatic nops(input int n);
    repeat (n) step(OP_NOP, 0, '0, 0);
  endtask

  task automatic instr(input bit [6:0] op);
    bit hit = 0;
    for (int k = 0; k < 12 && !hit; k++) begin
      step(op, 0, '0, 0);
      if (m_ph == 2) hit = 1;
    end
    if (!hit) timeouts++;
  endtask

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or chk_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp("FETCH_EN", 32'(bus.FETCH_EN), 32'(e.fe));
        cmp("EXEC_EN", 32'(bus.EXEC_EN), 32'(e.ee));
        cmp("INTR_EN", 32'(bus.INTR_EN), 32'(e.ie));
        cmp("RST", 32'(bus.RST), 32'(e.rst));
        cmp("I_FLAG", 32'(bus.I_FLAG), 32'(e.ifl));
        cmp("INT_ACK", 32'(bus.INT_ACK), 32'(e.ack));
        cmp("INT_VECTOR", 32'(bus.INT_VECTOR), 32'(e.vec));
        cmp("FLG_SHAD_LD", 32'(bus.FLG_SHAD_LD), 32'(e.sld));
        cmp("FLG_SHAD_RESTORE", 32'(bus.FLG_SHAD_RESTORE), 32'(e.srs));
        cmp("PENDING", 32'(bus.PENDING), 32'(e.pend));
        if (log_en && bus.INTR_EN === 1'b1) obs_log.push_back({bus.INT_ACK, bus.INT_VECTOR});
      end
      if (done) break;
    end
    cmp("ack_log_len", 32'(obs_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++)
      cmp($sformatf("ack_log[%0d]", i), 32'(obs_log[i]), 32'(exp_log[i]));
    cmp("stim_timeouts", 32'(timeouts), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // stimulus
  initial begin
    bit hit;
    int r;
    bus.OPCODE_HI_5 = '0; bus.OPCODE_LOW_2 = '0; bus.IRQ = '0;
    bus.MASK_WE = 0; bus.MASK_IN = '0;
    irq_v = '0; reedge = 0; done = 0; log_en = 1;
    d_op = '0; d_irq = '0; d_we = 0; d_min = '0;
    model_reset();
    exp_log.push_back({4'b0100, 10'h3FD});
    exp_log.push_back({4'b0010, 10'h3FE});
    exp_log.push_back({4'b1000, 10'h3FC});
    exp_log.push_back({4'b0001, 10'h3FF});
    exp_log.push_back({4'b0010, 10'h3FE});
    exp_log.push_back({4'b0010, 10'h3FE});
    exp_log.push_back({4'b0100, 10'h3FD});

    repeat (3) step(OP_NOP, 0, '0, 1);
    // channel 2 latched with I_FLAG=0, then SEI opens the gate one instruction later
    irq_v = 4'b0100;
    nops(5);
    instr(OP_SEI);
    nops(6);
    // simultaneous edges on 1 and 3: priority, then RETIE re-enables for the next
    irq_v = '0; nops(1);
    instr(OP_SEI);
    irq_v = 4'b1010;
    nops(8);
    instr(OP_RETIE);
    nops(6);
    // masked channel 0 latches but waits for unmask
    irq_v = '0;
    step(OP_NOP, 1, 4'b1110, 0);
    instr(OP_SEI);
    irq_v = 4'b0001;
    nops(6);
    step(OP_NOP, 1, 4'b1111, 0);
    nops(6);
    // re-edge of channel 1 during its own ack cycle keeps it pending
    irq_v = '0; nops(1);
    instr(OP_SEI);
    irq_v = 4'b0010; step(OP_NOP, 0, '0, 0);
    irq_v = '0; reedge = 1;
    nops(8);
    instr(OP_RETIE);
    nops(6);
    // asynchronous reset in the middle of INTR
    irq_v = '0; nops(1);
    instr(OP_SEI);
    irq_v = 4'b0100;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step(OP_NOP, 0, '0, 0);
      if (m_ph == 3) hit = 1;
    end
    if (!hit) timeouts++;
    @(negedge CLK); #2;
    RESET = 1; irq_v = '0; bus.IRQ = '0; d_irq = '0;
    #1;
    model_reset();
    q.push_back(expect_now());
    -> chk_now;
    step(OP_NOP, 0, '0, 1);
    step(OP_NOP, 0, '0, 0);
    nops(4);
    log_en = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bit [6:0] op;
      bit we, rs;
      bit [N-1:0] mi;
      r = $urandom_range(0, 99);
      if (r < 10) op = OP_SEI;
      else if (r < 16) op = OP_CLI;
      else if (r < 22) op = OP_RETIE;
      else if (r < 26) op = OP_RETID;
      else op = 7'($urandom);
      if ($urandom_range(0, 7) == 0) irq_v[$urandom_range(0, N-1)] ^= 1'b1;
      we = ($urandom_range(0, 15) == 0);
      mi = N'($urandom);
      rs = ($urandom_range(0, 399) == 0);
      step(op, we, mi, rs);
      if (rs) step(OP_NOP, 0, '0, 1);
    end
    step(OP_NOP, 0, '0, 0);
    done = 1;
  end
endmodule

// File: doc/rat_int_sequencer.md
Name: rat_int_sequencer

Overview:
- Parametrised successor to the RAT MCU control-unit state machine.
- Owns the instruction-cycle sequencer: INIT, FETCH, EXEC and INTR phases.
- Generalised to N_IRQ prioritised, individually maskable interrupt channels, each with its own vector.
- Owns the global interrupt-enable flag and the flag-shadow save/restore strobes.
- The opcode datapath decoder (ALU, register file, scratch RAM, stack) consumes its phase outputs.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..8).
- VEC_W, 10, PC/vector width.
- VEC_BASE, 10'h3FF, vector of channel 0; channel i vectors to VEC_BASE - i.
- OP_SEI, 7'b0110100, {hi5,low2} opcode for SEI.
- OP_CLI, 7'b0110101, opcode for CLI.
- OP_RETID, 7'b0110110, opcode for RETID.
- OP_RETIE, 7'b0110111, opcode for RETIE.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- OPCODE_HI_5  in  5  instruction register bits [17:13].
- OPCODE_LOW_2  in  2  instruction register bits [1:0].
- IRQ  in  N_IRQ  level interrupt requests; a rising edge requests service.
- MASK_WE  in  1  load the mask register from MASK_IN.
- MASK_IN  in  N_IRQ  new mask; 1 = channel enabled.
- FETCH_EN  out  1  high during FETCH.
- EXEC_EN  out  1  high during EXEC.
- INTR_EN  out  1  high during INTR.
- RST  out  1  datapath reset pulse; high during INIT.
- I_FLAG  out  1  global interrupt enable.
- INT_ACK  out  N_IRQ  one-hot acknowledge; valid during INTR only.
- INT_VECTOR  out  VEC_W  PC load value; valid during INTR, otherwise 0.
- FLG_SHAD_LD  out  1  save C/Z to shadow; high during INTR.
- FLG_SHAD_RESTORE  out  1  restore C/Z from shadow; high in EXEC of RETID/RETIE.
- PENDING  out  N_IRQ  latched request vector, for debug and status.

Behaviour:
- Reset (async, any state): state=INIT, I_FLAG=0, PENDING=0, mask=all ones, edge-detect/synchroniser registers=0.
- Output levels during reset: RST=1, all other outputs 0.
- State transitions, one state per clock:
  - INIT -> FETCH, unconditional.
  - FETCH -> EXEC.
  - EXEC -> INTR if (PENDING & mask) != 0 and I_FLAG=1 (registered value); else EXEC -> FETCH.
  - INTR -> FETCH.
- Phase outputs are one-hot decoded from state (Moore). Unused state encodings return to INIT.
- EXEC decode, effective at the end of the EXEC edge, on opcode = {OPCODE_HI_5, OPCODE_LOW_2}:
  - SEI: I_FLAG<=1.
  - CLI: I_FLAG<=0.
  - RETIE: FLG_SHAD_RESTORE=1, I_FLAG<=1.
  - RETID: FLG_SHAD_RESTORE=1, I_FLAG<=0.
  - Any other opcode leaves I_FLAG unchanged.
- The interrupt decision in the same EXEC uses the pre-update I_FLAG. An SEI therefore first allows entry at the following instruction's EXEC.
- INTR phase:
  - Selected channel = lowest index with PENDING&mask set (channel 0 highest priority).
  - INT_ACK = one-hot of the selected channel; INT_VECTOR = VEC_BASE - index (VEC_W-bit wrap).
  - FLG_SHAD_LD=1.
  - I_FLAG<=0 at end of the INTR edge.
  - PENDING[index] cleared at end of the INTR edge.
- Pending latch:
  - PENDING[i] is set on a detected rising edge of IRQ[i]. It stays set regardless of mask until acknowledged.
  - Masked channels latch but never cause entry. Unmasking later causes entry at the next eligible EXEC.
  - New edge on channel i in the same cycle as its ack: set wins, PENDING[i] stays 1.
- Mask register: loaded from MASK_IN on any clock with MASK_WE=1, independent of state. The new value first affects the next EXEC decision.
- Level held high does not re-request; only a new 0->1 transition does.
- RESET mid-INTR: the ack is abandoned and PENDING is cleared; the requesting source must re-edge.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each IRQ bit passes through a 2-flop synchroniser before edge detection.
  - IRQ first sampled high at edge k gives PENDING set at edge k+2.
- Undefined: edge detection compares IRQ directly against a 1-flop previous value.
  - IRQ sampled high at edge k gives PENDING set at edge k.
- The cycle counts in the Test Plan assume the macro is undefined, except where noted.

Test Plan:
- Reset release -> RST=1 for 1 cycle (INIT), then FETCH_EN/EXEC_EN alternate each cycle; I_FLAG=0, INT_ACK=0.
- IRQ=4'b0100 with I_FLAG=0 -> PENDING=4'b0100, no INTR.
  - Then execute SEI -> INTR entered at the following instruction's EXEC, not the SEI's own EXEC.
  - During INTR: INT_ACK=4'b0100, INT_VECTOR=10'h3FD, FLG_SHAD_LD=1; afterwards I_FLAG=0, PENDING=0.
- IRQ=4'b1010 same cycle, I_FLAG=1 -> first INTR acks 4'b0010 (vector 3FE).
  - RETIE -> FLG_SHAD_RESTORE=1, I_FLAG=1.
  - Next INTR acks 4'b1000 (vector 3FC).
- MASK_IN=4'b1110 with IRQ[0] edge, I_FLAG=1 -> PENDING[0]=1, no INTR.
  - Then MASK_IN=4'b1111 -> INTR at next EXEC, INT_VECTOR=10'h3FF.
- IRQ[1] re-edges in the INTR cycle acking channel 1 -> PENDING[1] remains 1; second INTR follows after RETIE.
- RESET asserted mid-INTR -> outputs drop asynchronously to reset values, PENDING=0, state=INIT.
  - With IRQ_SYNC_EN defined: edge-to-PENDING latency is 2 cycles longer than without.
